// File: rtl/adpll_defs.sv
// Shared ADPLL definitions: FSM encodings and default widths used by the
// edge rate meter and the phase accumulator.
package adpll_defs;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_GATE   = 2'd2
    } erm_state_t;

    localparam int GATE_LOG2_DEF = 12;
    localparam int CNT_WIDTH_DEF = 12;

endpackage

// File: rtl/sync_edge_detect.sv
// Brings an asynchronous level into the fpga_clk_i domain and flags each
// rising edge for exactly one cycle.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic fpga_clk_i,
    input  logic reset_i,
    input  logic async_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge fpga_clk_i) begin
        if (reset_i) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/edge_rate_meter.sv
// Counts rising edges of meas_clk_i over back-to-back gate windows of
// 2^GATE_LOG2 fpga_clk_i cycles and reports each completed window.
module edge_rate_meter
    import adpll_defs::*;
#(
    parameter int GATE_LOG2   = GATE_LOG2_DEF,
    parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 fpga_clk_i,
    input  logic                 reset_i,
    input  logic                 enable_i,
    input  logic                 meas_clk_i,
    output logic [CNT_WIDTH-1:0] count_o,
    output logic                 valid_o,
    output logic                 overflow_o,
    output logic                 busy_o
);

    localparam int                   SETTLE_W = $clog2(SYNC_STAGES + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    erm_state_t           state_q, state_d;
    logic [SETTLE_W-1:0]  settle_q;
    logic [GATE_LOG2-1:0] gate_q;
    logic                 settle_done, gate_last, count_en;

    logic                 rise_p0;
    logic [CNT_WIDTH-1:0] run_p1, run_nxt;
    logic                 sat_p1, sat_nxt;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                     input logic inc);
        return (inc && (v != CNT_MAX)) ? v + 1'b1 : v;
    endfunction

    function automatic logic sat_hit(input logic [CNT_WIDTH-1:0] v, input logic inc);
        return inc && (v == CNT_MAX);
    endfunction

    // Stage p0: synchronized edge strobe
    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .fpga_clk_i(fpga_clk_i),
        .reset_i   (reset_i),
        .async_i   (meas_clk_i),
        .rise_o    (rise_p0)
    );

    always_ff @(posedge fpga_clk_i) begin
        if (reset_i) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // The terminal GATE cycle still completes even when enable_i falls.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (enable_i) state_d = ST_SETTLE;
            ST_SETTLE: begin
                if (!enable_i)        state_d = ST_IDLE;
                else if (settle_done) state_d = ST_GATE;
            end
            ST_GATE:   if (!enable_i) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o      = (state_q != ST_IDLE);
        count_en    = (state_q == ST_GATE);
        gate_last   = count_en && (gate_q == '1);
        settle_done = (state_q == ST_SETTLE) && (settle_q == SETTLE_W'(SYNC_STAGES));
    end

    always_ff @(posedge fpga_clk_i) begin
        if (reset_i) begin
            settle_q <= '0;
            gate_q   <= '0;
        end else begin
            settle_q <= ((state_q == ST_SETTLE) && !settle_done) ? settle_q + 1'b1 : '0;
            gate_q   <= count_en ? gate_q + 1'b1 : '0;
        end
    end

    assign run_nxt = sat_inc(run_p1, rise_p0);
    assign sat_nxt = sat_p1 | sat_hit(run_p1, rise_p0);

    // Stage p1: running count; result registers load on the terminal cycle
    always_ff @(posedge fpga_clk_i) begin
        if (reset_i) begin
            run_p1     <= '0;
            sat_p1     <= 1'b0;
            count_o    <= '0;
            overflow_o <= 1'b0;
            valid_o    <= 1'b0;
        end else begin
            valid_o <= gate_last;
            if (gate_last) begin
                count_o    <= run_nxt;
                overflow_o <= sat_nxt;
                run_p1     <= '0;
                sat_p1     <= 1'b0;
            end else if (count_en) begin
                run_p1 <= run_nxt;
                sat_p1 <= sat_nxt;
            end else begin
                run_p1 <= '0;
                sat_p1 <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_edge_rate_meter.sv
// Scoreboard bench for edge_rate_meter: expected windows are queued by the
// stimulus process and consumed by per-instance monitors on valid_o.
module tb_edge_rate_meter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0, meas = 1'b0;
    logic en4 = 1'b0, meas4 = 1'b0;
    logic [7:0] cnt;
    logic       vld, ovf, busy;
    logic [3:0] cnt4;
    logic       vld4, ovf4, busy4;

    always #5 clk = ~clk;

    edge_rate_meter #(.GATE_LOG2(8), .CNT_WIDTH(8), .SYNC_STAGES(2)) dut (
        .fpga_clk_i(clk), .reset_i(rst), .enable_i(en), .meas_clk_i(meas),
        .count_o(cnt), .valid_o(vld), .overflow_o(ovf), .busy_o(busy)
    );

    edge_rate_meter #(.GATE_LOG2(8), .CNT_WIDTH(4), .SYNC_STAGES(2)) dut4 (
        .fpga_clk_i(clk), .reset_i(rst), .enable_i(en4), .meas_clk_i(meas4),
        .count_o(cnt4), .valid_o(vld4), .overflow_o(ovf4), .busy_o(busy4)
    );

    typedef struct {
        int   lo;
        int   hi;
        logic ovf;
        int   gap;
    } exp_t;

    exp_t q[$];
    exp_t q4[$];
    exp_t e_m, e_m4;
    int   got_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_vld = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    // Monitor for the 8-bit instance
    always @(negedge clk) begin
        if (vld) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid actual=%0d required=none", cnt);
            end else begin
                e_m = q.pop_front();
                check("count", int'(cnt), e_m.lo, e_m.hi);
                check("overflow", int'(ovf), int'(e_m.ovf), int'(e_m.ovf));
                if (e_m.gap > 0) check("valid_gap", cyc - last_vld, e_m.gap, e_m.gap);
            end
            got_q.push_back(int'(cnt));
            last_vld = cyc;
        end
    end

    // Monitor for the 4-bit instance
    always @(negedge clk) begin
        if (vld4) begin
            if (q4.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid4 actual=%0d required=none", cnt4);
            end else begin
                e_m4 = q4.pop_front();
                check("count4", int'(cnt4), e_m4.lo, e_m4.hi);
                check("overflow4", int'(ovf4), int'(e_m4.ovf), int'(e_m4.ovf));
            end
        end
    end

    // Stimulus generators: level, fixed period, or 8-bit phase accumulator k=37
    int         gmode = 0, gper = 16, glevel = 0, gcnt = 0;
    int         gper4 = 4, gcnt4 = 0;
    logic [7:0] acc = 8'd0;

    initial forever begin
        @(posedge clk);
        #1;
        case (gmode)
            0: meas = glevel[0];
            1: begin
                gcnt = (gcnt + 1) % gper;
                meas = (gcnt < gper / 2);
            end
            default: begin
                acc  = acc + 8'd37;
                meas = acc[7];
            end
        endcase
        gcnt4 = (gcnt4 + 1) % gper4;
        meas4 = (gcnt4 < gper4 / 2);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int budget);
        int b = 0;
        while ((q.size() != 0 || q4.size() != 0) && b < budget) begin
            @(posedge clk);
            b++;
        end
        #1;
        check("drain_pending", q.size() + q4.size(), 0, 0);
        q.delete();
        q4.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int s;
        rst = 1'b1;
        step(3);
        check("rst_count", int'(cnt), 0, 0);
        check("rst_overflow", int'(ovf), 0, 0);
        check("rst_valid", int'(vld), 0, 0);
        check("rst_busy", int'(busy), 0, 0);
        rst = 1'b0;
        step(2);

        // Period 16: three back-to-back windows of 16 edges, 256 cycles apart
        gmode = 1;
        gper  = 16;
        step(20);
        q.push_back('{16, 16, 1'b0, 0});
        q.push_back('{16, 16, 1'b0, 256});
        q.push_back('{16, 16, 1'b0, 256});
        en = 1'b1;
        wait_drain(1200);
        en = 1'b0;
        step(1);
        check("busy_after_disable", int'(busy), 0, 0);
        step(5);

        // Abort at GATE cycle 100: no valid, count holds
        en = 1'b1;
        step(104);
        en = 1'b0;
        step(1);
        check("abort_busy", int'(busy), 0, 0);
        check("abort_count_hold", int'(cnt), 16, 16);
        step(300);
        check("abort_count_hold2", int'(cnt), 16, 16);

        // enable falls in the terminal cycle: window still completes
        q.push_back('{16, 16, 1'b0, 0});
        en = 1'b1;
        step(259);
        en = 1'b0;
        step(1);
        check("term_valid", int'(vld), 1, 1);
        check("term_busy", int'(busy), 0, 0);
        wait_drain(10);
        step(5);

        // Phase accumulator k=37
        gmode = 2;
        step(10);
        got_q.delete();
        q.push_back('{36, 38, 1'b0, 0});
        for (int i = 0; i < 5; i++) q.push_back('{36, 38, 1'b0, 256});
        en = 1'b1;
        wait_drain(2000);
        en = 1'b0;
        check("pa_windows", got_q.size(), 6, 6);
        for (int i = 0; i + 3 < got_q.size(); i++) begin
            s = got_q[i] + got_q[i+1] + got_q[i+2] + got_q[i+3];
            check("pa_sum4", s, 147, 149);
        end
        step(5);

        // Constant levels: no edges
        gmode = 0;
        for (int lv = 1; lv >= 0; lv--) begin
            glevel = lv;
            step(10);
            q.push_back('{0, 0, 1'b0, 0});
            q.push_back('{0, 0, 1'b0, 256});
            en = 1'b1;
            wait_drain(800);
            en = 1'b0;
            step(5);
        end

        // Reset mid-window, then latency from enable to first valid
        gmode = 1;
        gper  = 16;
        step(20);
        q.push_back('{16, 16, 1'b0, 0});
        en = 1'b1;
        wait_drain(400);
        step(50);
        rst = 1'b1;
        step(1);
        check("midrst_count", int'(cnt), 0, 0);
        check("midrst_overflow", int'(ovf), 0, 0);
        check("midrst_valid", int'(vld), 0, 0);
        check("midrst_busy", int'(busy), 0, 0);
        rst = 1'b0;
        en  = 1'b0;
        step(5);
        q.push_back('{16, 16, 1'b0, 0});
        en = 1'b1;
        n = 0;
        while (!vld && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("enable_to_valid", n, 260, 260);
        wait_drain(10);
        en = 1'b0;
        step(5);

        // 4-bit counter: saturation, then a normal window
        gper4 = 4;
        step(10);
        q4.push_back('{15, 15, 1'b1, 0});
        en4 = 1'b1;
        wait_drain(400);
        en4 = 1'b0;
        step(5);
        gper4 = 32;
        step(40);
        q4.push_back('{8, 8, 1'b0, 0});
        en4 = 1'b1;
        wait_drain(400);
        en4 = 1'b0;
        step(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/edge_rate_meter.md
EDGE_RATE_METER -- requirements
Module: edge_rate_meter

Interface
REQ-001 The block SHALL have parameter GATE_LOG2, default 12, giving a gate window of 2^GATE_LOG2 fpga_clk_i cycles, matching phase-accumulator width so count equals k.
REQ-002 The block SHALL have parameter CNT_WIDTH, default 12, giving the width of the edge count result.
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2, minimum 2, giving the synchronizer depth for meas_clk_i.
REQ-004 fpga_clk_i  input  1  the single system clock; meas_clk_i is sampled by it.
REQ-005 reset_i  input  1  synchronous, active-high reset.
REQ-006 enable_i  input  1  level; 1 runs continuous back-to-back gate windows, 0 idles.
REQ-007 meas_clk_i  input  1  asynchronous clock under measurement (ring oscillator or phase-accumulator output).
REQ-008 count_o  output  CNT_WIDTH  rising edges counted in the last completed window.
REQ-009 valid_o  output  1  one-cycle pulse when count_o updates.
REQ-010 overflow_o  output  1  set when the last completed window saturated.
REQ-011 busy_o  output  1  high whenever the state is not IDLE.

Function
REQ-012 meas_clk_i SHALL pass through SYNC_STAGES flops, then one history flop; a rising edge SHALL be detected as synced=1, history=0, once per cycle.
REQ-013 The state machine SHALL have states IDLE, SETTLE and GATE.
REQ-014 IDLE -> SETTLE SHALL occur when enable_i=1; SETTLE SHALL last exactly SYNC_STAGES+1 cycles with no edges counted, then go to GATE.
REQ-015 GATE SHALL last 2^GATE_LOG2 cycles per window; each detected edge in any GATE cycle, including the terminal cycle, SHALL increment the running count.
REQ-016 On the terminal cycle, the running count plus any edge in that cycle SHALL load count_o, the running count SHALL clear, and the next window SHALL start the following cycle with no dead cycle.
REQ-017 valid_o SHALL be 1 in the cycle after the terminal cycle only; count_o and overflow_o SHALL hold until the next update.
REQ-018 The running count SHALL saturate at 2^CNT_WIDTH-1; overflow_o SHALL load 1 for a saturated window, otherwise 0.
REQ-019 enable_i=0 in SETTLE or GATE SHALL return to IDLE next cycle, discard the partial count, emit no valid_o, and leave count_o and overflow_o unchanged.
REQ-020 If enable_i falls in the terminal GATE cycle, that window SHALL still complete and pulse valid_o.
REQ-021 Inputs at or above fpga_clk_i/2 are out of range; the count SHALL then be undefined but bounded by saturation.

Reset
REQ-022 With reset_i=1 at a clock edge, state SHALL be IDLE, all synchronizer and history flops 0, and the running count, count_o, valid_o, overflow_o and busy_o all 0.
REQ-023 Reset SHALL take priority over enable_i, including mid-window, and SHALL emit no valid_o.

Structure
REQ-024 State encodings and default GATE_LOG2/CNT_WIDTH constants SHALL live in the shared adpll_defs package, also used by the phase accumulator.
REQ-025 The synchronizer and edge detector SHALL be one sub-module, sync_edge_detect (params SYNC_STAGES; ports fpga_clk_i, reset_i, async_i, rise_o).

Verification (GATE_LOG2=8, CNT_WIDTH=8, SYNC_STAGES=2 unless noted)
REQ-026 meas_clk_i period 16 cycles, enable_i held high -> every valid_o has count_o=16, overflow_o=0, valid_o spaced exactly 256 cycles apart.
REQ-027 meas_clk_i driven by an 8-bit phase accumulator with k=37 -> each count_o is 36, 37 or 38, and any 4 consecutive counts sum to 147-149.
REQ-028 meas_clk_i held 1 or 0 -> count_o=0 every window.
REQ-029 CNT_WIDTH=4, meas_clk_i period 4 -> count_o=15, overflow_o=1; then period 32 -> count_o=8, overflow_o=0.
REQ-030 enable_i dropped at GATE cycle 100 -> no valid_o, busy_o=0 next cycle, count_o keeps its prior value.
REQ-031 reset_i pulsed mid-window -> all outputs 0 next cycle; after re-enable, the first valid_o occurs exactly 3+256+1 cycles after enable_i rises.
